// File: rtl/icache_fill_engine.sv
// icache_fill_engine: refill writer for the L1 instruction cache.
// Takes one block-miss request, issues a single memory read, collects BEATS
// narrow data beats into a full block and strobes the i-cache write port once.
module icache_fill_engine #(
  parameter int unsigned BLOCK_BITS = 256,
  parameter int unsigned BEAT_BITS  = 32,
  parameter int unsigned ADDR_BITS  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  missValid_i,
  input  logic [ADDR_BITS-1:0]  missAddr_i,
  output logic                  missReady_o,
  output logic                  memReqValid_o,
  output logic [ADDR_BITS-1:0]  memReqAddr_o,
  input  logic                  memReqReady_i,
  input  logic                  memDataValid_i,
  input  logic [BEAT_BITS-1:0]  memData_i,
  output logic                  writeEnable_o,
  output logic [ADDR_BITS-1:0]  writeAddress_o,
  output logic [BLOCK_BITS-1:0] writeBlock_o,
  output logic                  fillDone_o
);

  localparam int unsigned BEATS = BLOCK_BITS / BEAT_BITS;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_BEAT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [ADDR_BITS-1:0]  w_addr_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BLOCK_BITS-1:0] r_block;
  logic [BLOCK_BITS-1:0] w_block_nxt;

  logic                  r_miss_ready;
  logic                  r_mem_req_valid;
  logic                  r_write_en;
  logic [ADDR_BITS-1:0]  r_wr_addr;

  // State, latched address, beat counter and the block being assembled
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_block <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_block <= w_block_nxt;
    end
  end

  // Next-state logic: accept miss, wait for request handshake, gather beats, write once
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_block_nxt = r_block;

    unique case (r_state)
      S_IDLE: begin
        if (missValid_i) begin
          w_addr_nxt  = missAddr_i;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        // Early data beats are dropped here on purpose.
        if (memReqReady_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_BEAT;
        end
      end

      S_BEAT: begin
        if (memDataValid_i) begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) begin
              w_block_nxt[b*BEAT_BITS +: BEAT_BITS] = memData_i;
            end
          end
          // Counter parks on the last index so it never wraps inside a fill.
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      S_WRITE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake and write-strobe outputs registered from the next state
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_miss_ready    <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_write_en      <= 1'b0;
      r_wr_addr       <= '0;
    end else begin
      r_miss_ready    <= (w_state_nxt == S_IDLE);
      r_mem_req_valid <= (w_state_nxt == S_REQ);
      r_write_en      <= (w_state_nxt == S_WRITE);
      if (w_state_nxt == S_WRITE) begin
        r_wr_addr <= r_addr;
      end
    end
  end

  assign missReady_o    = r_miss_ready;
  assign memReqValid_o  = r_mem_req_valid;
  assign memReqAddr_o   = r_addr;
  assign writeEnable_o  = r_write_en;
  assign fillDone_o     = r_write_en;
  assign writeAddress_o = r_wr_addr;
  assign writeBlock_o   = r_block;

endmodule
